// File: rtl/core_desc_dispatcher_pkg.sv
// Shared definitions for the descriptor dispatcher slice.
// Holds the default sizing constants, the dispatcher state type and a
// one-hot to index helper used to recover the offered core from the
// registered one-hot valid vector.
package core_desc_dispatcher_pkg;

  localparam int unsigned CORE_COUNT    = 16;
  localparam int unsigned CORE_ID_WIDTH = 4;
  localparam int unsigned SLOT_COUNT    = 8;
  localparam int unsigned SLOT_WIDTH    = $clog2(SLOT_COUNT + 1);
  localparam int unsigned DESC_WIDTH    = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // OR-reduction of the indices of set bits; exact for a one-hot input,
  // zero for an all-zero input.
  function automatic logic [CORE_ID_WIDTH-1:0] onehot_to_idx(
    input logic [CORE_COUNT-1:0] oh
  );
    logic [CORE_ID_WIDTH-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < CORE_COUNT; i++) begin
      if (oh[i]) idx = idx | CORE_ID_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/core_rr_select.sv
// Combinational round-robin picker.
//   eligible : per-core request vector
//   rr_ptr   : index of the last core served; search starts one above it
//   sel      : first eligible index at or after rr_ptr+1, modulo CORE_COUNT
//   any      : at least one core is eligible (sel is 0 when clear)
module core_rr_select
  import core_desc_dispatcher_pkg::*;
#(
  parameter int unsigned CORE_COUNT    = core_desc_dispatcher_pkg::CORE_COUNT,
  parameter int unsigned CORE_ID_WIDTH = core_desc_dispatcher_pkg::CORE_ID_WIDTH
) (
  input  logic [CORE_COUNT-1:0]    eligible,
  input  logic [CORE_ID_WIDTH-1:0] rr_ptr,
  output logic [CORE_ID_WIDTH-1:0] sel,
  output logic                     any
);

  logic [CORE_ID_WIDTH-1:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned off = 1; off <= CORE_COUNT; off++) begin
      idx = CORE_ID_WIDTH'((32'(rr_ptr) + off) % CORE_COUNT);
      if (!any && eligible[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/core_desc_dispatcher.sv
// Descriptor dispatcher: takes descriptors from the scheduler FIFO and
// offers each one to a single core, chosen round-robin among enabled cores
// that hold a free-slot credit.
//   sys_clk/sys_rst        : clock, synchronous active-high reset
//   s_desc/_valid/_ready   : incoming descriptor handshake (ready is comb)
//   core_desc              : registered descriptor shared by all cores
//   core_desc_valid        : one-hot offer, held until the core takes it
//   core_desc_taken        : per-core accept, only the offered bit matters
//   slot_release           : per-core credit return pulses
//   cfg_wr/cfg_core/cfg_credit : credit load, clamped to SLOT_COUNT
//   core_enable            : mask for future selections
//   dispatch_valid/_core   : one-cycle completion report
//   credit_err             : sticky release-at-full indication
module core_desc_dispatcher
  import core_desc_dispatcher_pkg::*;
#(
  parameter int unsigned CORE_COUNT    = core_desc_dispatcher_pkg::CORE_COUNT,
  parameter int unsigned CORE_ID_WIDTH = core_desc_dispatcher_pkg::CORE_ID_WIDTH,
  parameter int unsigned SLOT_COUNT    = core_desc_dispatcher_pkg::SLOT_COUNT,
  parameter int unsigned SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int unsigned DESC_WIDTH    = core_desc_dispatcher_pkg::DESC_WIDTH
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [DESC_WIDTH-1:0]    s_desc,
  input  logic                     s_desc_valid,
  output logic                     s_desc_ready,
  output logic [DESC_WIDTH-1:0]    core_desc,
  output logic [CORE_COUNT-1:0]    core_desc_valid,
  input  logic [CORE_COUNT-1:0]    core_desc_taken,
  input  logic [CORE_COUNT-1:0]    slot_release,
  input  logic                     cfg_wr,
  input  logic [CORE_ID_WIDTH-1:0] cfg_core,
  input  logic [SLOT_WIDTH-1:0]    cfg_credit,
  input  logic [CORE_COUNT-1:0]    core_enable,
  output logic                     dispatch_valid,
  output logic [CORE_ID_WIDTH-1:0] dispatch_core,
  output logic                     credit_err
);

  localparam logic [SLOT_WIDTH-1:0] SLOT_MAX = SLOT_WIDTH'(SLOT_COUNT);

  state_e                   state_q, state_d;
  logic [SLOT_WIDTH-1:0]    credit_q [CORE_COUNT];
  logic [SLOT_WIDTH-1:0]    credit_d [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [DESC_WIDTH-1:0]    core_desc_q, core_desc_d;
  logic [CORE_COUNT-1:0]    core_desc_valid_q, core_desc_valid_d;
  logic                     dispatch_valid_q, dispatch_valid_d;
  logic [CORE_ID_WIDTH-1:0] dispatch_core_q, dispatch_core_d;
  logic                     credit_err_q, credit_err_d;

  logic [CORE_COUNT-1:0]    eligible;
  logic [CORE_ID_WIDTH-1:0] sel;
  logic                     any;
  logic                     accept;
  logic                     taken;
  logic [CORE_ID_WIDTH-1:0] offer_idx;
  logic [CORE_COUNT-1:0]    dec_vec;
  logic [CORE_COUNT-1:0]    cfg_vec;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < CORE_COUNT; i++) begin
      eligible[i] = core_enable[i] && (credit_q[i] != '0);
    end
  end

  core_rr_select #(
    .CORE_COUNT    (CORE_COUNT),
    .CORE_ID_WIDTH (CORE_ID_WIDTH)
  ) u_rr_select (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .sel      (sel),
    .any      (any)
  );

  // Gating with sys_rst keeps the FIFO from popping a descriptor that the
  // reset edge would immediately discard.
  assign accept    = (state_q == IDLE) && s_desc_valid && any && !sys_rst;
  assign offer_idx = onehot_to_idx(core_desc_valid_q);
  assign taken     = (state_q == OFFER) && |(core_desc_taken & core_desc_valid_q);
  assign dec_vec   = accept ? (CORE_COUNT'(1) << sel) : '0;
  assign cfg_vec   = cfg_wr ? (CORE_COUNT'(1) << cfg_core) : '0;

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    core_desc_d       = core_desc_q;
    core_desc_valid_d = core_desc_valid_q;
    dispatch_valid_d  = 1'b0;
    dispatch_core_d   = dispatch_core_q;
    credit_err_d      = credit_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          core_desc_d       = s_desc;
          core_desc_valid_d = CORE_COUNT'(1) << sel;
          state_d           = OFFER;
        end
      end
      OFFER: begin
        if (taken) begin
          core_desc_valid_d = '0;
          dispatch_valid_d  = 1'b1;
          dispatch_core_d   = offer_idx;
          rr_ptr_d          = offer_idx;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A simultaneous decrement and release cancel out; a config load wins
    // over both on its own core.
    for (int unsigned i = 0; i < CORE_COUNT; i++) begin
      credit_d[i] = credit_q[i];
      if (cfg_vec[i]) begin
        credit_d[i] = (cfg_credit > SLOT_MAX) ? SLOT_MAX : cfg_credit;
      end else if (slot_release[i] && !dec_vec[i]) begin
        if (credit_q[i] == SLOT_MAX) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + SLOT_WIDTH'(1);
        end
      end else if (dec_vec[i] && !slot_release[i]) begin
        credit_d[i] = credit_q[i] - SLOT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q           <= IDLE;
      rr_ptr_q          <= CORE_ID_WIDTH'(CORE_COUNT - 1);
      core_desc_q       <= '0;
      core_desc_valid_q <= '0;
      dispatch_valid_q  <= 1'b0;
      dispatch_core_q   <= '0;
      credit_err_q      <= 1'b0;
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      core_desc_q       <= core_desc_d;
      core_desc_valid_q <= core_desc_valid_d;
      dispatch_valid_q  <= dispatch_valid_d;
      dispatch_core_q   <= dispatch_core_d;
      credit_err_q      <= credit_err_d;
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign s_desc_ready    = accept;
  assign core_desc       = core_desc_q;
  assign core_desc_valid = core_desc_valid_q;
  assign dispatch_valid  = dispatch_valid_q;
  assign dispatch_core   = dispatch_core_q;
  assign credit_err      = credit_err_q;

endmodule
